// File: rtl/fp_seq_pkg.sv
// Shared definitions for the FP dot-product sequencer.
// Contents: FPUnit operation codes, FP32 constants and the sequencer state type.
package fp_seq_pkg;

    localparam logic [1:0]  FP_OP_ADD = 2'b00;
    localparam logic [1:0]  FP_OP_MUL = 2'b10;

    localparam logic [31:0] FP_ZERO   = 32'h0000_0000;
    localparam logic [31:0] FP_QNAN   = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_MUL_ISSUE,
        ST_MUL_WAIT,
        ST_ADD_ISSUE,
        ST_ADD_WAIT,
        ST_RESULT
    } state_e;

endpackage

// File: rtl/fp_seq_watchdog.sv
// Cycle counter guarding FPUnit waits.
// Ports:
//   clk, resetn  clock, asynchronous active-low reset
//   clr_i        force the count to zero
//   en_i         count one cycle
//   tc_o         high while enabled on the last allowed wait cycle
module fp_seq_watchdog #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic resetn,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int             CNT_W  = $clog2(TIMEOUT_CYC + 1);
    // Count of completed wait cycles; the TIMEOUT_CYC-th wait cycle is the
    // last one in which fpu_done is still honoured.
    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = en_i && (cnt_q == TC_VAL);

endmodule

// File: rtl/fp_dot_sequencer.sv
// Sequences FPUnit multiply/add operations to compute acc = sum(x_i * w_i).
// Configuration macro: FP_DOT_RELU_EN (clamps negative results to +0.0).
// Ports:
//   clk, resetn                  clock, asynchronous active-low reset
//   cmd_valid/cmd_ready/cmd_len  dot-product request (element count)
//   in_valid/in_ready/in_x/in_w  operand pair stream (FP32)
//   fpu_op/fpu_a/fpu_b/fpu_start FPUnit request, operands held until fpu_done
//   fpu_done/fpu_res             FPUnit completion
//   res_valid/res_ready/res_data FP32 result
//   busy, err_timeout            status; err_timeout is sticky until next command
// Handshakes: a transfer happens on a rising clk edge where valid and ready are
// both high; the producer holds valid and data stable until that edge.
module fp_dot_sequencer
    import fp_seq_pkg::*;
#(
    parameter int LEN_W       = 8,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_x,
    input  logic [31:0]      in_w,
    output logic [1:0]       fpu_op,
    output logic [31:0]      fpu_a,
    output logic [31:0]      fpu_b,
    output logic             fpu_start,
    input  logic             fpu_done,
    input  logic [31:0]      fpu_res,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic             busy,
    output logic             err_timeout
);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic [31:0]      x_q, x_d, w_q, w_d, prod_q, prod_d, acc_q, acc_d;
    logic             err_q, err_d;
    logic             in_wait, wd_tc;
    logic [31:0]      final_val;

    assign in_wait = (state_q == ST_MUL_WAIT) || (state_q == ST_ADD_WAIT);

    fp_seq_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
        .clk    (clk),
        .resetn (resetn),
        .clr_i  (!in_wait),
        .en_i   (in_wait),
        .tc_o   (wd_tc)
    );

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; fpu_done wins over a same-cycle watchdog expiry.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (cmd_valid) state_d = (cmd_len == '0) ? ST_RESULT : ST_FETCH;
            ST_FETCH:     if (in_valid) state_d = ST_MUL_ISSUE;
            ST_MUL_ISSUE: state_d = ST_MUL_WAIT;
            ST_MUL_WAIT: begin
                if (fpu_done)   state_d = ST_ADD_ISSUE;
                else if (wd_tc) state_d = ST_RESULT;
            end
            ST_ADD_ISSUE: state_d = ST_ADD_WAIT;
            ST_ADD_WAIT: begin
                if (fpu_done)   state_d = (count_q == LEN_W'(1)) ? ST_RESULT : ST_FETCH;
                else if (wd_tc) state_d = ST_RESULT;
            end
            ST_RESULT:    if (res_ready) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // Datapath next-state
    always_comb begin
        count_d = count_q;
        x_d     = x_q;
        w_d     = w_q;
        prod_d  = prod_q;
        acc_d   = acc_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    count_d = cmd_len;
                    acc_d   = FP_ZERO;
                    err_d   = 1'b0;
                end
            end
            ST_FETCH: begin
                if (in_valid) begin
                    x_d = in_x;
                    w_d = in_w;
                end
            end
            ST_MUL_WAIT: begin
                if (fpu_done)   prod_d = fpu_res;
                else if (wd_tc) err_d  = 1'b1;
            end
            ST_ADD_WAIT: begin
                if (fpu_done) begin
                    acc_d   = fpu_res;
                    count_d = count_q - 1'b1;
                end else if (wd_tc) begin
                    err_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
            x_q     <= '0;
            w_q     <= '0;
            prod_q  <= '0;
            acc_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            x_q     <= x_d;
            w_q     <= w_d;
            prod_q  <= prod_d;
            acc_q   <= acc_d;
            err_q   <= err_d;
        end
    end

`ifdef FP_DOT_RELU_EN
    assign final_val = acc_q[31] ? FP_ZERO : acc_q;
`else
    assign final_val = acc_q;
`endif

    // Outputs. Operands are driven from state so they stay stable from the
    // start pulse through the whole wait. cmd_ready is gated by resetn so
    // every output reads 0 while reset is asserted.
    always_comb begin
        cmd_ready = resetn && (state_q == ST_IDLE);
        in_ready  = (state_q == ST_FETCH);
        fpu_start = (state_q == ST_MUL_ISSUE) || (state_q == ST_ADD_ISSUE);
        fpu_op    = FP_OP_ADD;
        fpu_a     = FP_ZERO;
        fpu_b     = FP_ZERO;
        res_valid = 1'b0;
        res_data  = FP_ZERO;
        case (state_q)
            ST_MUL_ISSUE, ST_MUL_WAIT: begin
                fpu_op = FP_OP_MUL;
                fpu_a  = x_q;
                fpu_b  = w_q;
            end
            ST_ADD_ISSUE, ST_ADD_WAIT: begin
                fpu_op = FP_OP_ADD;
                fpu_a  = acc_q;
                fpu_b  = prod_q;
            end
            ST_RESULT: begin
                res_valid = 1'b1;
                res_data  = err_q ? FP_QNAN : final_val;
            end
            default: ;
        endcase
        busy        = (state_q != ST_IDLE);
        err_timeout = err_q;
    end

endmodule

// File: tb/tb_fp_dot_sequencer.sv
// Directed bench for fp_dot_sequencer with a behavioural FPUnit model.
module tb_fp_dot_sequencer;

    localparam int LEN_W = 8;
    localparam int TO    = 255;

    logic             clk = 1'b0;
    logic             resetn;
    logic             cmd_valid, cmd_ready;
    logic [LEN_W-1:0] cmd_len;
    logic             in_valid, in_ready;
    logic [31:0]      in_x, in_w;
    logic [1:0]       fpu_op;
    logic [31:0]      fpu_a, fpu_b;
    logic             fpu_start;
    logic             fpu_done;
    logic [31:0]      fpu_res;
    logic             res_valid, res_ready;
    logic [31:0]      res_data;
    logic             busy, err_timeout;

    int vectors     = 0;
    int miscompares = 0;
    logic [31:0] exp_q[$];

    // FPUnit model controls/state
    int   fpu_delay = 0;
    logic withhold  = 1'b0;
    int   start_cnt = 0;
    int   cyc       = 0;

    always #5 clk = ~clk;

    fp_dot_sequencer #(.LEN_W(LEN_W), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_w(in_w),
        .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_start(fpu_start),
        .fpu_done(fpu_done), .fpu_res(fpu_res),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .busy(busy), .err_timeout(err_timeout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic fail_bound(input string tag);
        vectors++;
        miscompares++;
        $error("FAIL %s wait bound expired", tag);
    endtask

    // Exact conversions for normal/zero FP32 values used here.
    function automatic real sp2r(input logic [31:0] b);
        logic [63:0] d;
        if (b[30:0] == 31'd0) d = {b[31], 63'd0};
        else d = {b[31], 11'(b[30:23]) + 11'd896, b[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2sp(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        e = d[62:52] - 11'd896;
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        return {d[63], e[7:0], d[51:29]};
    endfunction

    // Behavioural FPUnit: sees start at the negedge, answers fpu_delay+1 cycles later.
    initial begin : fpu_model
        logic        pend;
        int          wl;
        logic [1:0]  cap_op;
        logic [31:0] cap_a, cap_b, m_res;
        logic        mul_flag;
        int          done_cyc;
        pend = 0; wl = 0; mul_flag = 0; done_cyc = 0;
        cap_op = 0; cap_a = 0; cap_b = 0; m_res = 0;
        fpu_done = 1'b0;
        fpu_res  = 32'h0;
        forever begin
            @(negedge clk);
            cyc++;
            fpu_done = 1'b0;
            fpu_res  = 32'h0;
            if (!resetn) begin
                pend = 0;
                mul_flag = 0;
            end else if (pend) begin
                check("op_stable", {30'd0, fpu_op}, {30'd0, cap_op});
                check("a_stable", fpu_a, cap_a);
                check("b_stable", fpu_b, cap_b);
                check("no_restart", {31'd0, fpu_start}, 32'd0);
                if (wl == 0) begin
                    fpu_done = 1'b1;
                    fpu_res  = m_res;
                    pend     = 0;
                    if (cap_op == 2'b10) begin
                        mul_flag = 1;
                        done_cyc = cyc;
                    end
                end else begin
                    wl--;
                end
            end else if (fpu_start) begin
                if (mul_flag) check("done_to_add_latency", cyc, done_cyc + 1);
                mul_flag = 0;
                start_cnt++;
                if (!withhold) begin
                    cap_op = fpu_op;
                    cap_a  = fpu_a;
                    cap_b  = fpu_b;
                    if (fpu_op == 2'b10) m_res = r2sp(sp2r(fpu_a) * sp2r(fpu_b));
                    else                 m_res = r2sp(sp2r(fpu_a) + sp2r(fpu_b));
                    pend = 1;
                    wl   = fpu_delay;
                end
            end
        end
    end

    // All driver tasks are entered and left at a negedge.
    task automatic send_cmd(input int len);
        int k;
        cmd_valid = 1'b1;
        cmd_len   = LEN_W'(len);
        for (k = 0; k < 100 && !cmd_ready; k++) @(negedge clk);
        if (!cmd_ready) fail_bound("cmd_accept");
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic send_pair(input logic [31:0] x, input logic [31:0] w);
        int k;
        in_valid = 1'b1;
        in_x = x;
        in_w = w;
        for (k = 0; k < 2000 && !in_ready; k++) @(negedge clk);
        if (!in_ready) fail_bound("pair_accept");
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic collect(input int holdoff);
        int k;
        logic [31:0] e;
        for (k = 0; k < 2000 && !res_valid; k++) @(negedge clk);
        if (!res_valid) begin
            fail_bound("res_valid");
        end else begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
            check("res_data", res_data, e);
            for (int i = 0; i < holdoff; i++) begin
                @(negedge clk);
                check("hold_res_valid", {31'd0, res_valid}, 32'd1);
                check("hold_res_data", res_data, e);
                check("hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            end
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
            check("res_valid_drop", {31'd0, res_valid}, 32'd0);
        end
    endtask

    initial begin : main
        int s0;
        int k;
        logic [31:0] xs [3];
        logic [31:0] ws [3];
        resetn = 1'b0; cmd_valid = 1'b0; cmd_len = '0;
        in_valid = 1'b0; in_x = '0; in_w = '0; res_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_fpu_start", {31'd0, fpu_start}, 32'd0);
        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_err", {31'd0, err_timeout}, 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        check("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // 1: single element 2.0 * 3.0
        fpu_delay = 2;
        s0 = start_cnt;
        exp_q.push_back(32'h40C0_0000);
        send_cmd(1);
        send_pair(32'h4000_0000, 32'h4040_0000);
        check("mul_start_latency", {31'd0, fpu_start}, 32'd1);
        check("mul_op", {30'd0, fpu_op}, 32'd2);
        check("mul_a", fpu_a, 32'h4000_0000);
        check("mul_b", fpu_b, 32'h4040_0000);
        collect(0);
        check("t1_starts", start_cnt - s0, 2);

        // 2: three elements, varying FPUnit latency
        xs = '{32'h3F80_0000, 32'h4040_0000, 32'hBF80_0000};
        ws = '{32'h4000_0000, 32'h4080_0000, 32'h40A0_0000};
        s0 = start_cnt;
        exp_q.push_back(32'h4110_0000);
        send_cmd(3);
        for (int i = 0; i < 3; i++) begin
            fpu_delay = $urandom_range(0, 5);
            send_pair(xs[i], ws[i]);
        end
        collect(0);
        check("t2_starts", start_cnt - s0, 6);

        // 3: zero length
        s0 = start_cnt;
        exp_q.push_back(32'h0);
        send_cmd(0);
        check("len0_res_valid", {31'd0, res_valid}, 32'd1);
        collect(0);
        check("t3_starts", start_cnt - s0, 0);

        // 4: result back-pressure, 4.0 * 0.5
        fpu_delay = 1;
        exp_q.push_back(32'h4000_0000);
        send_cmd(1);
        send_pair(32'h4080_0000, 32'h3F00_0000);
        collect(10);

        // 5: FPUnit never answers
        withhold = 1'b1;
        send_cmd(1);
        send_pair(32'h3F80_0000, 32'h3F80_0000);
        check("t5_start", {31'd0, fpu_start}, 32'd1);
        for (k = 0; k < 400 && !err_timeout; k++) @(negedge clk);
        if (!err_timeout) fail_bound("timeout_flag");
        else check("timeout_cycles", k, TO + 1);
        exp_q.push_back(32'h7FC0_0000);
        collect(0);
        check("err_sticky", {31'd0, err_timeout}, 32'd1);
        exp_q.push_back(32'h0);
        send_cmd(0);
        check("err_cleared", {31'd0, err_timeout}, 32'd0);
        collect(0);

        // 6: reset while waiting on the multiply, then a negative result
        send_cmd(1);
        send_pair(32'h3F80_0000, 32'h4000_0000);
        repeat (3) @(negedge clk);
        check("t6_busy", {31'd0, busy}, 32'd1);
        #2 resetn = 1'b0;
        #1;
        check("arst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("arst_in_ready", {31'd0, in_ready}, 32'd0);
        check("arst_fpu_start", {31'd0, fpu_start}, 32'd0);
        check("arst_fpu_op", {30'd0, fpu_op}, 32'd0);
        check("arst_fpu_a", fpu_a, 32'd0);
        check("arst_fpu_b", fpu_b, 32'd0);
        check("arst_res_valid", {31'd0, res_valid}, 32'd0);
        check("arst_res_data", res_data, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_err", {31'd0, err_timeout}, 32'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        withhold = 1'b0;
        fpu_delay = 0;
        @(negedge clk);
`ifdef FP_DOT_RELU_EN
        exp_q.push_back(32'h0000_0000);
`else
        exp_q.push_back(32'hC0C0_0000);
`endif
        send_cmd(1);
        send_pair(32'hC000_0000, 32'h4040_0000);
        collect(0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
